piso_shiftregister: RTL and testbench

PISO_SHIFTREGISTER -- requirements
Module: piso_shiftregister

---
 rtl/piso_shiftregister.sv | 105 ++++++++++
 tb/tb_piso_shiftregister.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/piso_shiftregister.sv
// Parallel-in / serial-out shift register.
// Accepts a WIDTH-bit word through a valid/ready handshake and presents it
// one bit per cycle on sout, MSB or LSB first. A new word may be accepted
// in the cycle that carries the final bit of the current one, giving a
// gap-free serial stream.
module piso_shiftregister #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             sout_n;
    logic             sout_valid_n;
    logic             done_n;
    logic             accept;

    // Bit that leaves the word first, according to the configured order.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST != 0) begin
            return w[WIDTH-1];
        end
        return w[0];
    endfunction

    // Word with the head bit removed, moving the next bit into head position.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        if (MSB_FIRST != 0) begin
            return {w[WIDTH-2:0], 1'b0};
        end
        return {1'b0, w[WIDTH-1:1]};
    endfunction

    // Ready while idle or while the final bit of the current word is out.
    assign load_ready = (state == IDLE) || (cnt == '0);
    assign accept     = load_valid && load_ready;

    // Next-state and next-output logic; outputs default to the idle pattern.
    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        cnt_n        = cnt;
        sout_n       = 1'b0;
        sout_valid_n = 1'b0;
        done_n       = 1'b0;

        if (accept) begin
            // Capture the word and launch its first bit on the next cycle.
            state_n      = SHIFT;
            shreg_n      = pin;
            cnt_n        = CNT_LAST;
            sout_n       = head_bit(pin);
            sout_valid_n = 1'b1;
        end else if (state == SHIFT) begin
            if (cnt != '0) begin
                shreg_n      = shift_word(shreg);
                cnt_n        = cnt - CW'(1);
                sout_n       = head_bit(shift_word(shreg));
                sout_valid_n = 1'b1;
                done_n       = (cnt == CW'(1));
            end else begin
                // Final bit was presented and nothing followed it.
                state_n = IDLE;
            end
        end
    end

    // State, datapath and registered outputs; reset aborts any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            cnt        <= cnt_n;
            sout       <= sout_n;
            sout_valid <= sout_valid_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_piso_shiftregister.sv
// Directed bench for piso_shiftregister: an MSB-first and an LSB-first
// instance (WIDTH=4) share the same stimulus.
module tb_piso_shiftregister;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pin = 4'b0000;
    logic       load_valid = 1'b0;

    logic rdy_m, so_m, sv_m, dn_m;
    logic rdy_l, so_l, sv_l, dn_l;

    int total = 0;
    int bad   = 0;

    piso_shiftregister #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .pin(pin), .load_valid(load_valid),
        .load_ready(rdy_m), .sout(so_m), .sout_valid(sv_m), .done(dn_m)
    );

    piso_shiftregister #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .pin(pin), .load_valid(load_valid),
        .load_ready(rdy_l), .sout(so_l), .sout_valid(sv_l), .done(dn_l)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       lv;
        logic [3:0] pin;
        logic       so_m;
        logic       so_l;
        logic       sv;
        logic       dn;
        logic       rdy;
    } vec_t;

    vec_t vecs[28];

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic e_so_m, input logic e_so_l,
                           input logic e_sv, input logic e_dn, input logic e_rdy);
        chk("sout_msb", idx, so_m, e_so_m);
        chk("sout_lsb", idx, so_l, e_so_l);
        chk("valid_msb", idx, sv_m, e_sv);
        chk("valid_lsb", idx, sv_l, e_sv);
        chk("done_msb", idx, dn_m, e_dn);
        chk("done_lsb", idx, dn_l, e_dn);
        chk("ready_msb", idx, rdy_m, e_rdy);
        chk("ready_lsb", idx, rdy_l, e_rdy);
    endtask

    // Drive inputs on the falling edge, sample outputs just after it.
    task automatic step(input logic lv, input logic [3:0] p);
        @(negedge clk);
        load_valid = lv;
        pin        = p;
        #1;
    endtask

    function automatic vec_t mk(input logic lv, input logic [3:0] p, input logic a,
                                input logic b, input logic v, input logic d, input logic r);
        vec_t t;
        t.lv = lv; t.pin = p; t.so_m = a; t.so_l = b; t.sv = v; t.dn = d; t.rdy = r;
        return t;
    endfunction

    initial begin
        // Single word 1001 (same order both ways).
        vecs[0]  = mk(1, 4'b1001, 0, 0, 0, 0, 1);
        vecs[1]  = mk(0, 4'b0000, 1, 1, 1, 0, 0);
        vecs[2]  = mk(0, 4'b0000, 0, 0, 1, 0, 0);
        vecs[3]  = mk(0, 4'b0000, 0, 0, 1, 0, 0);
        vecs[4]  = mk(0, 4'b0000, 1, 1, 1, 1, 1);
        vecs[5]  = mk(0, 4'b0000, 0, 0, 0, 0, 1);
        // Back-to-back 1010 then 0110 with load_valid held.
        vecs[6]  = mk(1, 4'b1010, 0, 0, 0, 0, 1);
        vecs[7]  = mk(1, 4'b0110, 1, 0, 1, 0, 0);
        vecs[8]  = mk(1, 4'b0110, 0, 1, 1, 0, 0);
        vecs[9]  = mk(1, 4'b0110, 1, 0, 1, 0, 0);
        vecs[10] = mk(1, 4'b0110, 0, 1, 1, 1, 1);
        vecs[11] = mk(0, 4'b0000, 0, 0, 1, 0, 0);
        vecs[12] = mk(0, 4'b0000, 1, 1, 1, 0, 0);
        vecs[13] = mk(0, 4'b0000, 1, 1, 1, 0, 0);
        vecs[14] = mk(0, 4'b0000, 0, 0, 1, 1, 1);
        vecs[15] = mk(0, 4'b0000, 0, 0, 0, 0, 1);
        // Busy ignore: 1100, stray load of 0011 during bit 2, pin wiggles after.
        vecs[16] = mk(1, 4'b1100, 0, 0, 0, 0, 1);
        vecs[17] = mk(0, 4'b1100, 1, 0, 1, 0, 0);
        vecs[18] = mk(1, 4'b0011, 1, 0, 1, 0, 0);
        vecs[19] = mk(0, 4'b0101, 0, 1, 1, 0, 0);
        vecs[20] = mk(0, 4'b1010, 0, 1, 1, 1, 1);
        vecs[21] = mk(0, 4'b0000, 0, 0, 0, 0, 1);
        // 1101: MSB 1,1,0,1 and LSB 1,0,1,1.
        vecs[22] = mk(1, 4'b1101, 0, 0, 0, 0, 1);
        vecs[23] = mk(0, 4'b0000, 1, 1, 1, 0, 0);
        vecs[24] = mk(0, 4'b0000, 1, 0, 1, 0, 0);
        vecs[25] = mk(0, 4'b0000, 0, 1, 1, 0, 0);
        vecs[26] = mk(0, 4'b0000, 1, 1, 1, 1, 1);
        vecs[27] = mk(0, 4'b0000, 0, 0, 0, 0, 1);

        // Reset with load_valid asserted: must be ignored.
        rst = 1'b1;
        load_valid = 1'b1;
        pin = 4'b1111;
        repeat (3) @(negedge clk);
        #1;
        chk_all(100, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        load_valid = 1'b0;
        pin = 4'b0000;

        // Idle hygiene for 10 cycles after reset.
        for (int i = 0; i < 10; i++) begin
            step(0, 4'b0000);
            chk_all(200 + i, 0, 0, 0, 0, 1);
        end

        // Table-driven vectors.
        for (int i = 0; i < 28; i++) begin
            step(vecs[i].lv, vecs[i].pin);
            chk_all(i, vecs[i].so_m, vecs[i].so_l, vecs[i].sv, vecs[i].dn, vecs[i].rdy);
        end

        // Reset mid-word: 1111, reset asserted while bit 2 is on sout.
        step(1, 4'b1111);
        chk_all(300, 0, 0, 0, 0, 1);
        step(0, 4'b0000);
        chk_all(301, 1, 1, 1, 0, 0);
        step(0, 4'b0000);
        chk_all(302, 1, 1, 1, 0, 0);
        rst = 1'b1;
        #1;
        chk_all(303, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 4'b1010);
            chk_all(310 + i, 0, 0, 0, 0, 1);
        end
        @(negedge clk);
        rst = 1'b0;
        load_valid = 1'b0;
        #1;
        chk_all(320, 0, 0, 0, 0, 1);
        // Aborted word must not resume nor pulse done.
        step(0, 4'b0000);
        chk_all(321, 0, 0, 0, 0, 1);
        step(0, 4'b0000);
        chk_all(322, 0, 0, 0, 0, 1);
        // New word 0101: MSB 0,1,0,1; LSB 1,0,1,0.
        step(1, 4'b0101);
        chk_all(330, 0, 0, 0, 0, 1);
        step(0, 4'b0000);
        chk_all(331, 0, 1, 1, 0, 0);
        step(0, 4'b0000);
        chk_all(332, 1, 0, 1, 0, 0);
        step(0, 4'b0000);
        chk_all(333, 0, 1, 1, 0, 0);
        step(0, 4'b0000);
        chk_all(334, 1, 0, 1, 1, 1);
        step(0, 4'b0000);
        chk_all(335, 0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
